// File: rtl/request_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : request_scheduler
//  Description : Round-robin time-sharing of the actuator code path among the
//                five sensor requesters (SFD, SRD, SFA, SW, ST). Each grant is
//                held for a minimum number of cycles, and an all-off guard gap
//                separates two different grants. All outputs are registered.
//  Revision    : 1.0  initial release
// ============================================================================
module request_scheduler #(
  parameter int HOLD_CYCLES = 8,
  parameter int GAP_CYCLES  = 2,
  parameter int T_LOW       = 18,
  parameter int T_HIGH      = 30
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       SFD,
  input  logic       SRD,
  input  logic       SFA,
  input  logic       SW,
  input  logic       ST,
  input  logic [5:0] temperature,
  output logic [2:0] display,
  output logic [4:0] grant,
  output logic       busy
);

  localparam int c_cnt_max = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
  localparam int c_cw      = $clog2(c_cnt_max + 1);

  typedef logic [c_cw-1:0] cnt_t;

  localparam cnt_t       c_hold_load = cnt_t'(HOLD_CYCLES - 1);
  localparam cnt_t       c_gap_load  = (GAP_CYCLES > 0) ? cnt_t'(GAP_CYCLES - 1) : '0;
  localparam logic [5:0] c_t_low     = 6'(T_LOW);
  localparam logic [5:0] c_t_high    = 6'(T_HIGH);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_HOLD = 2'd1,
    S_GAP  = 2'd2
  } state_t;

  state_t     r_state, w_state_nxt;
  cnt_t       r_hold_cnt, w_hold_cnt_nxt;
  cnt_t       r_gap_cnt, w_gap_cnt_nxt;
  logic [2:0] r_ptr, w_ptr_nxt;
  logic [2:0] r_display, w_display_nxt;
  logic [4:0] r_grant, w_grant_nxt;

  logic       w_temp_low;
  logic       w_temp_high;
  logic [2:0] w_st_code;
  logic [4:0] w_req;
  logic       w_any;
  logic [2:0] w_win;
  logic       w_extend;
  logic       w_arbitrate;

  // Position k steps after base in the 5-entry ring.
  function automatic logic [2:0] f_ring(input logic [2:0] base, input int k);
    int s;
    s = int'(base) + k;
    if (s >= 5) s = s - 5;
    return 3'(s);
  endfunction

  // Actuator code for a requester index; ST's code depends on the band side.
  function automatic logic [2:0] f_code(input logic [2:0] idx, input logic [2:0] st_code);
    logic [2:0] c;
    case (idx)
      3'd0:    c = 3'b001;
      3'd1:    c = 3'b010;
      3'd2:    c = 3'b011;
      3'd3:    c = 3'b100;
      default: c = st_code;
    endcase
    return c;
  endfunction

  // Request vector; ST only requests when the temperature is strictly out of band.
  always_comb begin
    w_temp_low  = (temperature < c_t_low);
    w_temp_high = (temperature > c_t_high);
    w_st_code   = w_temp_low ? 3'b101 : 3'b110;
    w_req       = {ST & (w_temp_low | w_temp_high), SW, SFA, SRD, SFD};
  end

  // Round-robin pick: scan from ptr downward so the nearest requester wins last.
  always_comb begin
    w_any = 1'b0;
    w_win = 3'd0;
    for (int k = 4; k >= 0; k--) begin
      if (w_req[f_ring(r_ptr, k)]) begin
        w_any = 1'b1;
        w_win = f_ring(r_ptr, k);
      end
    end
  end

  // Extension only when the current holder is the sole requester.
  always_comb begin
    w_extend = (|(w_req & r_grant)) & ~(|(w_req & ~r_grant));
  end

  // Next-state and registered-output values.
  always_comb begin
    w_state_nxt    = r_state;
    w_hold_cnt_nxt = r_hold_cnt;
    w_gap_cnt_nxt  = r_gap_cnt;
    w_ptr_nxt      = r_ptr;
    w_display_nxt  = r_display;
    w_grant_nxt    = r_grant;
    w_arbitrate    = 1'b0;

    case (r_state)
      S_IDLE: begin
        w_arbitrate = 1'b1;
      end
      S_HOLD: begin
        if (r_hold_cnt != '0) begin
          w_hold_cnt_nxt = r_hold_cnt - cnt_t'(1);
        end else if (w_extend) begin
          w_hold_cnt_nxt = c_hold_load;
          if (r_grant[4]) w_display_nxt = w_st_code;
        end else if (GAP_CYCLES > 0) begin
          w_state_nxt   = S_GAP;
          w_gap_cnt_nxt = c_gap_load;
          w_display_nxt = 3'b000;
          w_grant_nxt   = 5'b00000;
        end else begin
          w_arbitrate = 1'b1;
        end
      end
      S_GAP: begin
        if (r_gap_cnt != '0) begin
          w_gap_cnt_nxt = r_gap_cnt - cnt_t'(1);
        end else begin
          w_arbitrate = 1'b1;
        end
      end
      default: begin
        w_state_nxt   = S_IDLE;
        w_display_nxt = 3'b000;
        w_grant_nxt   = 5'b00000;
      end
    endcase

    if (w_arbitrate) begin
      if (w_any) begin
        w_state_nxt    = S_HOLD;
        w_hold_cnt_nxt = c_hold_load;
        w_display_nxt  = f_code(w_win, w_st_code);
        w_grant_nxt    = 5'b00001 << w_win;
        w_ptr_nxt      = (w_win == 3'd4) ? 3'd0 : w_win + 3'd1;
      end else begin
        w_state_nxt   = S_IDLE;
        w_display_nxt = 3'b000;
        w_grant_nxt   = 5'b00000;
      end
    end
  end

  // State, counters, pointer and output registers; reset aborts any grant at once.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= S_IDLE;
      r_hold_cnt <= '0;
      r_gap_cnt  <= '0;
      r_ptr      <= 3'd0;
      r_display  <= 3'b000;
      r_grant    <= 5'b00000;
    end else begin
      r_state    <= w_state_nxt;
      r_hold_cnt <= w_hold_cnt_nxt;
      r_gap_cnt  <= w_gap_cnt_nxt;
      r_ptr      <= w_ptr_nxt;
      r_display  <= w_display_nxt;
      r_grant    <= w_grant_nxt;
    end
  end

  assign display = r_display;
  assign grant   = r_grant;
  assign busy    = (r_state != S_IDLE);

endmodule
`default_nettype wire
